// File: rtl/vmem_seq_if.sv
// Handshake and memory-port bundle between the vector controller, the memory
// and the vmem_seq transfer sequencer.
interface vmem_seq_if #(
    parameter int AW    = 16,
    parameter int DW    = 16,
    parameter int NELEM = 16
);
    logic                  Start;
    logic [1:0]            Op;
    logic [AW-1:0]         Base;
    logic [AW-1:0]         Stride;
    logic                  Abort;
    logic [NELEM*DW-1:0]   VecIn;
    logic [DW-1:0]         SclIn;
    logic [DW-1:0]         DataIn;
    logic [AW-1:0]         Addr;
    logic                  RD;
    logic                  WR;
    logic [DW-1:0]         DataOut;
    logic [NELEM*DW-1:0]   VecOut;
    logic                  VecWE;
    logic                  Busy;
    logic                  Done;
    logic                  Err;

    modport master (
        output Start, Op, Base, Stride, Abort, VecIn, SclIn, DataIn,
        input  Addr, RD, WR, DataOut, VecOut, VecWE, Busy, Done, Err
    );

    modport slave (
        input  Start, Op, Base, Stride, Abort, VecIn, SclIn, DataIn,
        output Addr, RD, WR, DataOut, VecOut, VecWE, Busy, Done, Err
    );
endinterface

// File: rtl/vmem_seq.sv
// Vector memory-transfer sequencer: vld / vst / sst over the shared memory port,
// with configurable element count, element width and address stride.
module vmem_seq #(
    parameter int AW    = 16,
    parameter int DW    = 16,
    parameter int NELEM = 16,
    parameter int CW    = 5
) (
    input  logic        Clk1,
    input  logic        Reset,
    vmem_seq_if.slave   bus
);
    localparam int IW = (NELEM > 1) ? $clog2(NELEM) : 1;

    localparam logic [1:0] OP_VLD = 2'b00;
    localparam logic [1:0] OP_SST = 2'b10;
    localparam logic [1:0] OP_ILL = 2'b11;

    typedef enum logic [1:0] {IDLE, XFER, DRAIN, FIN} state_t;

    typedef struct packed {
        logic [1:0]    op;
        logic [AW-1:0] stride;
        logic [DW-1:0] scl;
    } cmd_t;

    state_t                      state_q, state_d;
    cmd_t                        cmd_q;
    logic [NELEM-1:0][DW-1:0]    vec_q;
    logic [NELEM-1:0][DW-1:0]    vec_out_q;
    logic [CW-1:0]               cnt_q;
    logic [AW-1:0]               addr_q;
    logic                        rd_q;
    logic [IW-1:0]               cap_idx_q;
    logic                        err_q;
    logic                        abort_q;

    logic is_vld, is_sst, last, accept, illegal;
    logic rd, wr, busy, done, vec_we;

    assign is_vld  = (cmd_q.op == OP_VLD);
    assign is_sst  = (cmd_q.op == OP_SST);
    assign last    = is_sst || (cnt_q == CW'(NELEM-1));
    assign accept  = (state_q == IDLE) && bus.Start && (bus.Op != OP_ILL);
    assign illegal = (state_q == IDLE) && bus.Start && (bus.Op == OP_ILL);

    always_ff @(posedge Clk1) begin
        if (Reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        rd      = 1'b0;
        wr      = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        vec_we  = 1'b0;
        case (state_q)
            IDLE: if (accept) state_d = XFER;
            XFER: begin
                busy = 1'b1;
                rd   = is_vld;
                wr   = !is_vld;
                if (bus.Abort)  state_d = FIN;
                else if (last)  state_d = is_vld ? DRAIN : FIN;
            end
            DRAIN: begin
                busy    = 1'b1;
                state_d = FIN;
            end
            FIN: begin
                done    = 1'b1;
                vec_we  = is_vld && !abort_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk1) begin
        if (Reset) begin
            cmd_q     <= '0;
            vec_q     <= '0;
            vec_out_q <= '0;
            cnt_q     <= '0;
            addr_q    <= '0;
            rd_q      <= 1'b0;
            cap_idx_q <= '0;
            err_q     <= 1'b0;
            abort_q   <= 1'b0;
        end else begin
            err_q <= illegal;
            if (accept) begin
                cmd_q.op     <= bus.Op;
                cmd_q.stride <= bus.Stride;
                cmd_q.scl    <= bus.SclIn;
                vec_q        <= bus.VecIn;
                cnt_q        <= '0;
                addr_q       <= bus.Base;
                abort_q      <= 1'b0;
            end else if (state_q == XFER) begin
                cnt_q  <= cnt_q + 1'b1;
                addr_q <= addr_q + cmd_q.stride;
            end
            if ((state_q == XFER || state_q == DRAIN) && bus.Abort)
                abort_q <= 1'b1;
            // Read data returns one cycle after RD; track which element it belongs to.
            rd_q      <= rd;
            cap_idx_q <= cnt_q[IW-1:0];
            if (rd_q)
                vec_out_q[cap_idx_q] <= bus.DataIn;
        end
    end

    assign bus.Addr    = addr_q;
    assign bus.RD      = rd;
    assign bus.WR      = wr;
    assign bus.DataOut = wr ? (is_sst ? cmd_q.scl : vec_q[cnt_q[IW-1:0]]) : '0;
    assign bus.VecOut  = vec_out_q;
    assign bus.VecWE   = vec_we;
    assign bus.Busy    = busy;
    assign bus.Done    = done;
    assign bus.Err     = err_q;
endmodule

// File: tb/tb_vmem_seq.sv
// Directed bench for vmem_seq: a table of transfers checked cycle by cycle
// against a memory model (word at a = a ^ 0xA5A5), plus Err and reset sequences.
module tb_vmem_seq;
    localparam int AW = 16, DW = 16, NELEM = 16;

    logic Clk1 = 1'b0;
    logic Reset = 1'b1;
    always #5 Clk1 = ~Clk1;

    vmem_seq_if #(.AW(AW), .DW(DW), .NELEM(NELEM)) bus ();
    vmem_seq #(.AW(AW), .DW(DW), .NELEM(NELEM), .CW(5)) dut (
        .Clk1(Clk1), .Reset(Reset), .bus(bus)
    );

    always @(posedge Clk1) bus.DataIn <= bus.RD ? (bus.Addr ^ 16'hA5A5) : 16'h0000;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge Clk1);
        #1;
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [15:0] base;
        logic [15:0] stride;
        logic [15:0] scl;
        int          abort_at;
        int          done_cyc;
        bit          vec_we;
        int          n_rd;
        int          n_wr;
    } vec_t;

    vec_t tbl[9];

    task automatic run(input vec_t v, input string tag);
        int nrd = 0, nwr = 0, dcyc = -1, nchk;
        logic [15:0] ea, ed;
        bus.Start  = 1'b1;
        bus.Op     = v.op;
        bus.Base   = v.base;
        bus.Stride = v.stride;
        bus.SclIn  = v.scl;
        bus.Abort  = (v.abort_at == 0);
        for (int c = 1; c <= 40 && dcyc < 0; c++) begin
            tick;
            bus.Start = 1'b0;
            bus.Abort = (c == v.abort_at);
            check({tag, " rd_wr_excl"}, bus.RD & bus.WR, 0);
            check({tag, " busy"}, bus.Busy, (c < v.done_cyc));
            check({tag, " vecwe"}, bus.VecWE, (c == v.done_cyc) && v.vec_we);
            if (bus.RD) begin
                ea = v.base + v.stride * 16'(nrd);
                check({tag, " rd_addr"}, bus.Addr, ea);
                nrd++;
            end
            if (bus.WR) begin
                ea = v.base + v.stride * 16'(nwr);
                ed = (v.op == 2'b10) ? v.scl : 16'(nwr + 16'h10);
                check({tag, " wr_addr"}, bus.Addr, ea);
                check({tag, " wr_data"}, bus.DataOut, ed);
                nwr++;
            end
            if (bus.Done) dcyc = c;
        end
        bus.Abort = 1'b0;
        check({tag, " done_cycle"}, dcyc, v.done_cyc);
        check({tag, " n_rd"}, nrd, v.n_rd);
        check({tag, " n_wr"}, nwr, v.n_wr);
        tick;
        check({tag, " done_pulse_end"}, bus.Done, 0);
        if (v.op == 2'b00) begin
            nchk = (v.abort_at > 0 && v.abort_at <= 16) ? v.abort_at - 1 : NELEM;
            for (int i = 0; i < nchk; i++) begin
                ed = (v.base + v.stride * 16'(i)) ^ 16'hA5A5;
                check({tag, " vecout_elem"}, bus.VecOut[i*16 +: 16], ed);
            end
        end
    endtask

    initial begin
        tbl[0] = '{2'd0, 16'h0100, 16'h0001, 16'h0000, -1, 18, 1'b1, 16, 0};
        tbl[1] = '{2'd1, 16'hFFFE, 16'h0002, 16'h0000, -1, 17, 1'b0, 0, 16};
        tbl[2] = '{2'd2, 16'h0040, 16'h0000, 16'hBEEF, -1, 2,  1'b0, 0, 1};
        tbl[3] = '{2'd0, 16'h0200, 16'hFFFF, 16'h0000, -1, 18, 1'b1, 16, 0};
        tbl[4] = '{2'd0, 16'h0300, 16'h0000, 16'h0000, -1, 18, 1'b1, 16, 0};
        tbl[5] = '{2'd0, 16'h0100, 16'h0001, 16'h0000, 5,  6,  1'b0, 5, 0};
        tbl[6] = '{2'd1, 16'h2000, 16'h0003, 16'h0000, 3,  4,  1'b0, 0, 3};
        tbl[7] = '{2'd0, 16'h0400, 16'h0004, 16'h0000, 17, 18, 1'b0, 16, 0};
        tbl[8] = '{2'd1, 16'h3000, 16'h0001, 16'h0000, 0,  17, 1'b0, 0, 16};

        bus.Start = 1'b0; bus.Op = 2'b00; bus.Base = '0; bus.Stride = '0;
        bus.Abort = 1'b0; bus.SclIn = '0;
        for (int i = 0; i < NELEM; i++) bus.VecIn[i*16 +: 16] = 16'(i + 16'h10);

        tick; tick;
        check("rst addr", bus.Addr, 0);
        check("rst rd", bus.RD, 0);
        check("rst wr", bus.WR, 0);
        check("rst dout", bus.DataOut, 0);
        check("rst vecout", (bus.VecOut != '0), 0);
        check("rst vecwe", bus.VecWE, 0);
        check("rst busy", bus.Busy, 0);
        check("rst done", bus.Done, 0);
        check("rst err", bus.Err, 0);
        Reset = 1'b0;
        tick;

        for (int k = 0; k < 9; k++) run(tbl[k], $sformatf("v%0d", k));

        // Illegal op: Err pulse only, then a normal vld is accepted.
        bus.Start = 1'b1; bus.Op = 2'b11; bus.Base = 16'h0500;
        tick;
        bus.Start = 1'b0;
        check("ill err", bus.Err, 1);
        check("ill rdwr", bus.RD | bus.WR, 0);
        check("ill busy", bus.Busy, 0);
        tick;
        check("ill err_end", bus.Err, 0);
        check("ill busy2", bus.Busy | bus.RD | bus.WR, 0);
        run(tbl[0], "after_ill");

        // vst interrupted by reset at cycle 8, with a Start pulsed while busy.
        bus.Start = 1'b1; bus.Op = 2'b01; bus.Base = 16'h1000; bus.Stride = 16'h0001;
        for (int c = 1; c <= 8; c++) begin
            tick;
            bus.Start = (c == 3);
            bus.Op    = (c == 3) ? 2'b00 : 2'b01;
            check("rstx wr", bus.WR, 1);
            check("rstx addr", bus.Addr, 16'h1000 + 16'(c - 1));
            check("rstx data", bus.DataOut, 16'(c - 1 + 16'h10));
        end
        bus.Start = 1'b0;
        Reset = 1'b1;
        tick;
        check("rstx addr0", bus.Addr, 0);
        check("rstx outs0", {bus.RD, bus.WR, bus.VecWE, bus.Busy, bus.Done, bus.Err}, 0);
        check("rstx dout0", bus.DataOut, 0);
        check("rstx vecout0", (bus.VecOut != '0), 0);
        Reset = 1'b0;
        begin
            logic act;
            act = 1'b0;
            for (int c = 0; c < 20; c++) begin
                tick;
                act |= bus.RD | bus.WR | bus.Busy | bus.Done | bus.VecWE;
            end
            check("rstx idle_after", act, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule
